// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular trace of {PC, writeback data} pairs that stops on a selectable
// trigger (immediate, PC match, halt) and exposes the frozen trace through a registered read port.
module wb_trace_buffer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int STALL_LIMIT = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DATA_W-1:0] PC_in,
   input  logic [DATA_W-1:0] WB_data_in,
   input  logic              WB_valid,
   input  logic              arm,
   input  logic [1:0]        trig_mode,
   input  logic [DATA_W-1:0] trig_pc,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_pc,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic [1:0]        state,
   output logic              done,
   output logic              halt_detect
);

   localparam int                STALL_W    = $clog2(STALL_LIMIT);
   localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT - 1);
   localparam logic [ADDR_W-1:0]  POST_LAST  = ADDR_W'(DEPTH / 2 - 1);
   localparam logic [ADDR_W:0]    COUNT_FULL = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } stateT;

   stateT               r_state;
   logic [ADDR_W-1:0]   r_wrPtr;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W-1:0]   r_postCnt;
   logic [STALL_W-1:0]  r_stallCnt;
   logic                r_halt;
   logic                r_done;
   logic [DATA_W-1:0]   r_prevPc;
   logic [DATA_W-1:0]   r_rdPc;
   logic [DATA_W-1:0]   r_rdData;
   logic [DATA_W-1:0]   r_memPc   [DEPTH];
   logic [DATA_W-1:0]   r_memData [DEPTH];

   logic                w_armTake;
   logic                w_wrEn;
   logic                w_repeat;
   logic                w_haltRise;
   logic                w_trigger;
   logic [ADDR_W-1:0]   w_oldest;
   logic [ADDR_W-1:0]   w_rdIdx;
   logic                w_rdHit;

   assign w_armTake  = arm && ((r_state == IDLE) || (r_state == DONE));
   assign w_wrEn     = WB_valid && ((r_state == ARMED) || (r_state == CAPTURE));
   assign w_repeat   = (r_state != IDLE) && (PC_in == r_prevPc);
   assign w_haltRise = w_repeat && (r_stallCnt == STALL_MAX) && !r_halt;

   // Halt mode fires on the same edge that sets halt_detect, so the flag and CAPTURE appear together.
   always_comb begin
      w_trigger = 1'b0;
      case (trig_mode)
         2'd0:    w_trigger = 1'b1;
         2'd1:    w_trigger = (PC_in == trig_pc);
         2'd2:    w_trigger = w_haltRise;
         default: w_trigger = 1'b0;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= IDLE;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_postCnt  <= '0;
         r_stallCnt <= '0;
         r_halt     <= 1'b0;
         r_done     <= 1'b0;
         r_prevPc   <= '0;
      end else begin
         r_prevPc <= PC_in;
         if (w_armTake) begin
            r_state    <= ARMED;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_postCnt  <= '0;
            r_stallCnt <= '0;
            r_halt     <= 1'b0;
            r_done     <= 1'b0;
         end else begin
            if (r_state != IDLE) begin
               if (w_repeat) begin
                  if (r_stallCnt != STALL_MAX)
                     r_stallCnt <= r_stallCnt + 1'b1;
                  else
                     r_halt <= 1'b1;
               end else begin
                  r_stallCnt <= '0;
               end
            end
            if (w_wrEn) begin
               r_wrPtr <= r_wrPtr + 1'b1;
               if (r_count != COUNT_FULL)
                  r_count <= r_count + 1'b1;
            end
            // A write in the trigger cycle is post-trigger entry 1; DONE follows the DEPTH/2-th one.
            case (r_state)
               ARMED: begin
                  if (w_trigger) begin
                     r_state   <= CAPTURE;
                     r_postCnt <= w_wrEn ? ADDR_W'(1) : '0;
                  end
               end
               CAPTURE: begin
                  if (w_wrEn) begin
                     r_postCnt <= r_postCnt + 1'b1;
                     if (r_postCnt == POST_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (w_wrEn) begin
         r_memPc[r_wrPtr]   <= PC_in;
         r_memData[r_wrPtr] <= WB_data_in;
      end
   end

   // When the buffer is full the count's low bits are zero, so oldest lands on the write pointer.
   assign w_oldest = r_wrPtr - r_count[ADDR_W-1:0];
   assign w_rdIdx  = w_oldest + rd_addr;
   assign w_rdHit  = ({1'b0, rd_addr} < r_count);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_rdPc   <= '0;
         r_rdData <= '0;
      end else if (w_rdHit) begin
         r_rdPc   <= r_memPc[w_rdIdx];
         r_rdData <= r_memData[w_rdIdx];
      end else begin
         r_rdPc   <= '0;
         r_rdData <= '0;
      end
   end

   assign rd_pc       = r_rdPc;
   assign rd_data     = r_rdData;
   assign count       = r_count;
   assign state       = r_state;
   assign done        = r_done;
   assign halt_detect = r_halt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed sequence over trigger modes, wrap, halt detection and reset,
// with a queue model of the trace contents feeding a read-port scoreboard.
module tb_wb_trace_buffer;

   localparam int DATA_W      = 32;
   localparam int DEPTH       = 16;
   localparam int ADDR_W      = 4;
   localparam int STALL_LIMIT = 8;

   logic              Clk = 1'b0;
   logic              Rst;
   logic [DATA_W-1:0] PC_in;
   logic [DATA_W-1:0] WB_data_in;
   logic              WB_valid;
   logic              arm;
   logic [1:0]        trig_mode;
   logic [DATA_W-1:0] trig_pc;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_pc;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   count;
   logic [1:0]        state;
   logic              done;
   logic              halt_detect;

   int nChecks = 0;
   int nFail   = 0;
   bit modelOn = 1'b0;
   logic [63:0] modelBuf[$];
   logic [63:0] expQ[$];

   wb_trace_buffer #(
      .DATA_W(DATA_W),
      .DEPTH(DEPTH),
      .ADDR_W(ADDR_W),
      .STALL_LIMIT(STALL_LIMIT)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .PC_in(PC_in),
      .WB_data_in(WB_data_in),
      .WB_valid(WB_valid),
      .arm(arm),
      .trig_mode(trig_mode),
      .trig_pc(trig_pc),
      .rd_addr(rd_addr),
      .rd_pc(rd_pc),
      .rd_data(rd_data),
      .count(count),
      .state(state),
      .done(done),
      .halt_detect(halt_detect)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before end of sequence");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One writeback cycle; the model records it only while a capture is expected to be running.
   task automatic applyStimulus(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] data);
      PC_in      = pc;
      WB_data_in = data;
      WB_valid   = 1'b1;
      if (modelOn) begin
         modelBuf.push_back({pc, data});
         if (modelBuf.size() > DEPTH)
            void'(modelBuf.pop_front());
      end
      tick();
      WB_valid = 1'b0;
   endtask

   task automatic checkRead(input string tag, input int addr);
      logic [63:0] exp;
      rd_addr = ADDR_W'(addr);
      exp = (addr < modelBuf.size()) ? modelBuf[addr] : 64'h0;
      expQ.push_back(exp);
      tick();
      checkOutput(tag, {rd_pc, rd_data}, expQ.pop_front());
   endtask

   initial begin
      Rst        = 1'b1;
      arm        = 1'b0;
      WB_valid   = 1'b0;
      PC_in      = '0;
      WB_data_in = '0;
      trig_mode  = 2'd0;
      trig_pc    = '0;
      rd_addr    = '0;
      tick();
      tick();
      Rst = 1'b0;
      tick();
      checkOutput("reset_state", 64'(state), 64'd0);
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_halt", 64'(halt_detect), 64'd0);
      checkOutput("reset_rd", {rd_pc, rd_data}, 64'h0);

      // Immediate trigger: eight writes fill the post-trigger half and stop.
      trig_mode = 2'd0;
      PC_in     = 32'h1F0;
      arm       = 1'b1;
      tick();
      arm = 1'b0;
      modelBuf.delete();
      modelOn = 1'b1;
      checkOutput("m0_armed", 64'(state), 64'd1);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(32'(4 * k), 32'(k));
         if (k == 6)
            checkOutput("m0_capture_before_last", 64'(state), 64'd2);
      end
      modelOn = 1'b0;
      checkOutput("m0_done_state", 64'(state), 64'd3);
      checkOutput("m0_done_flag", 64'(done), 64'd1);
      checkOutput("m0_count", 64'(count), 64'd8);
      applyStimulus(32'h999, 32'hDEAD);
      checkOutput("m0_frozen_count", 64'(count), 64'd8);
      checkRead("m0_rd0", 0);
      checkRead("m0_rd7", 7);
      checkRead("m0_rd8_beyond", 8);

      // Arm from DONE with a simultaneous writeback; arm wins and nothing is written.
      trig_mode  = 2'd1;
      trig_pc    = 32'h40;
      PC_in      = 32'h77;
      WB_data_in = 32'h55;
      WB_valid   = 1'b1;
      arm        = 1'b1;
      tick();
      arm      = 1'b0;
      WB_valid = 1'b0;
      modelBuf.delete();
      modelOn = 1'b1;
      checkOutput("rearm_state", 64'(state), 64'd1);
      checkOutput("rearm_count", 64'(count), 64'd0);
      checkOutput("rearm_halt", 64'(halt_detect), 64'd0);

      // PC-match trigger at 0x40 after sixteen pre-trigger writes; buffer wraps.
      for (int k = 0; k < 24; k++) begin
         applyStimulus(32'(4 * k), 32'h1000 + 32'(k));
         if (k == 15) begin
            checkOutput("m1_pretrig_state", 64'(state), 64'd1);
            checkOutput("m1_full_count", 64'(count), 64'd16);
         end
         if (k == 16)
            checkOutput("m1_trig_state", 64'(state), 64'd2);
      end
      modelOn = 1'b0;
      checkOutput("m1_done_state", 64'(state), 64'd3);
      checkOutput("m1_sat_count", 64'(count), 64'd16);
      checkRead("m1_rd0_oldest", 0);
      checkRead("m1_rd7", 7);
      checkRead("m1_rd8_trigpc", 8);
      checkRead("m1_rd15_last", 15);
      checkOutput("m1_rd15_pc_const", 64'(rd_pc), 64'h5C);

      // Halt detector keeps running in DONE: set on the eighth repeat, not the seventh.
      PC_in = 32'h200;
      tick();
      for (int r = 0; r < STALL_LIMIT - 1; r++)
         tick();
      checkOutput("done_halt_not_yet", 64'(halt_detect), 64'd0);
      tick();
      checkOutput("done_halt_set", 64'(halt_detect), 64'd1);
      checkOutput("done_halt_state", 64'(state), 64'd3);

      trig_mode = 2'd2;
      PC_in     = 32'h300;
      WB_valid  = 1'b1;
      arm       = 1'b1;
      tick();
      arm      = 1'b0;
      WB_valid = 1'b0;
      modelBuf.delete();
      modelOn = 1'b1;
      checkOutput("m2_arm_state", 64'(state), 64'd1);
      checkOutput("m2_arm_count", 64'(count), 64'd0);
      checkOutput("m2_arm_halt_cleared", 64'(halt_detect), 64'd0);

      // Halt trigger: PC parks at 0x5C with no further writebacks.
      applyStimulus(32'h50, 32'd1);
      applyStimulus(32'h54, 32'd2);
      applyStimulus(32'h58, 32'd3);
      applyStimulus(32'h5C, 32'd4);
      for (int r = 0; r < STALL_LIMIT - 1; r++)
         tick();
      checkOutput("m2_halt_not_yet", 64'(halt_detect), 64'd0);
      checkOutput("m2_still_armed", 64'(state), 64'd1);
      tick();
      checkOutput("m2_halt_set", 64'(halt_detect), 64'd1);
      checkOutput("m2_capture", 64'(state), 64'd2);
      checkOutput("m2_count", 64'(count), 64'd4);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      checkOutput("m2_arm_ignored_state", 64'(state), 64'd2);
      checkOutput("m2_arm_ignored_count", 64'(count), 64'd4);
      checkOutput("m2_arm_ignored_halt", 64'(halt_detect), 64'd1);
      checkRead("m2_rd3", 3);
      checkOutput("m2_hold_capture", 64'(state), 64'd2);

      // Asynchronous reset between clock edges must take effect immediately.
      #2;
      Rst = 1'b1;
      #1;
      modelOn = 1'b0;
      modelBuf.delete();
      checkOutput("async_rst_state", 64'(state), 64'd0);
      checkOutput("async_rst_count", 64'(count), 64'd0);
      checkOutput("async_rst_halt", 64'(halt_detect), 64'd0);
      checkOutput("async_rst_rd", {rd_pc, rd_data}, 64'h0);
      tick();
      Rst = 1'b0;
      tick();
      checkOutput("post_rst_idle", 64'(state), 64'd0);
      checkRead("post_rst_rd0", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
